// File: rtl/mem_wr_router.sv
`default_nettype none
// ============================================================================
// Module      : mem_wr_router
// Description : Routes single-cycle CPU-bus writes to one of four targets
//               (CTL register file, MOD, DUTY or STM BRAM). Snoops controller
//               writes to track the segment and page registers that extend
//               the 14-bit bus offset into full BRAM addresses.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_wr_router #(
    parameter int STM_WR_ADDR_WIDTH = 18,
    parameter int DUTY_ADDR_WIDTH   = 15
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         CPU_WE,
    input  logic [15:0]                  CPU_ADDR,
    input  logic [15:0]                  CPU_DATA,
    output logic                         CTL_WE,
    output logic [13:0]                  CTL_ADDR,
    output logic [15:0]                  CTL_DATA,
    output logic                         MOD_WE,
    output logic                         MOD_SEGMENT,
    output logic [13:0]                  MOD_ADDR,
    output logic [15:0]                  MOD_DATA,
    output logic                         DUTY_WE,
    output logic [DUTY_ADDR_WIDTH-1:0]   DUTY_ADDR,
    output logic [15:0]                  DUTY_DATA,
    output logic                         STM_WE,
    output logic                         STM_SEGMENT,
    output logic [STM_WR_ADDR_WIDTH-1:0] STM_ADDR,
    output logic [15:0]                  STM_DATA
);

    localparam int c_STM_PAGE_W  = STM_WR_ADDR_WIDTH - 14;
    localparam int c_DUTY_PAGE_W = DUTY_ADDR_WIDTH - 14;

    localparam logic [1:0] c_SEL_CTL  = 2'd0;
    localparam logic [1:0] c_SEL_MOD  = 2'd1;
    localparam logic [1:0] c_SEL_DUTY = 2'd2;
    localparam logic [1:0] c_SEL_STM  = 2'd3;

    // Controller register offsets whose writes are mirrored locally
    localparam logic [13:0] c_OFF_MOD_SEG   = 14'h0020;
    localparam logic [13:0] c_OFF_STM_SEG   = 14'h0050;
    localparam logic [13:0] c_OFF_STM_PAGE  = 14'h0058;
    localparam logic [13:0] c_OFF_DUTY_PAGE = 14'h0060;

    logic [1:0]               w_sel;
    logic [13:0]              w_off;
    logic                     r_mod_seg;
    logic                     r_stm_seg;
    logic [c_STM_PAGE_W-1:0]  r_stm_page;
    logic [c_DUTY_PAGE_W-1:0] r_duty_page;

    assign w_sel = CPU_ADDR[15:14];
    assign w_off = CPU_ADDR[13:0];

    // Output stage: one-hot write strobe per accepted write; address/data
    // of unselected targets hold. Page/segment used here are the values in
    // effect before this edge, since a BRAM write never updates them.
    always_ff @(posedge CLK) begin
        if (RST) begin
            CTL_WE      <= 1'b0;
            CTL_ADDR    <= '0;
            CTL_DATA    <= '0;
            MOD_WE      <= 1'b0;
            MOD_SEGMENT <= 1'b0;
            MOD_ADDR    <= '0;
            MOD_DATA    <= '0;
            DUTY_WE     <= 1'b0;
            DUTY_ADDR   <= '0;
            DUTY_DATA   <= '0;
            STM_WE      <= 1'b0;
            STM_SEGMENT <= 1'b0;
            STM_ADDR    <= '0;
            STM_DATA    <= '0;
        end else begin
            CTL_WE  <= 1'b0;
            MOD_WE  <= 1'b0;
            DUTY_WE <= 1'b0;
            STM_WE  <= 1'b0;
            if (CPU_WE) begin
                case (w_sel)
                    c_SEL_CTL: begin
                        CTL_WE   <= 1'b1;
                        CTL_ADDR <= w_off;
                        CTL_DATA <= CPU_DATA;
                    end
                    c_SEL_MOD: begin
                        MOD_WE      <= 1'b1;
                        MOD_SEGMENT <= r_mod_seg;
                        MOD_ADDR    <= w_off;
                        MOD_DATA    <= CPU_DATA;
                    end
                    c_SEL_DUTY: begin
                        DUTY_WE   <= 1'b1;
                        DUTY_ADDR <= {r_duty_page, w_off};
                        DUTY_DATA <= CPU_DATA;
                    end
                    c_SEL_STM: begin
                        STM_WE      <= 1'b1;
                        STM_SEGMENT <= r_stm_seg;
                        STM_ADDR    <= {r_stm_page, w_off};
                        STM_DATA    <= CPU_DATA;
                    end
                    default: begin
                        CTL_WE <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Snoop of controller writes: mirror segment and page registers so a
    // BRAM write on the very next cycle already sees the new value.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_mod_seg   <= 1'b0;
            r_stm_seg   <= 1'b0;
            r_stm_page  <= '0;
            r_duty_page <= '0;
        end else if (CPU_WE && (w_sel == c_SEL_CTL)) begin
            case (w_off)
                c_OFF_MOD_SEG:   r_mod_seg   <= CPU_DATA[0];
                c_OFF_STM_SEG:   r_stm_seg   <= CPU_DATA[0];
                c_OFF_STM_PAGE:  r_stm_page  <= CPU_DATA[c_STM_PAGE_W-1:0];
                c_OFF_DUTY_PAGE: r_duty_page <= CPU_DATA[c_DUTY_PAGE_W-1:0];
                default: begin
                    r_mod_seg <= r_mod_seg;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_wr_router.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_wr_router
// Description : Self-checking bench for mem_wr_router. A transaction-level
//               model predicts every output each cycle; directed sequences
//               additionally pin hand-computed values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_wr_router;

    localparam int c_STM_W  = 18;
    localparam int c_DUTY_W = 15;

    logic                CLK;
    logic                RST;
    logic                CPU_WE;
    logic [15:0]         CPU_ADDR;
    logic [15:0]         CPU_DATA;
    logic                CTL_WE;
    logic [13:0]         CTL_ADDR;
    logic [15:0]         CTL_DATA;
    logic                MOD_WE;
    logic                MOD_SEGMENT;
    logic [13:0]         MOD_ADDR;
    logic [15:0]         MOD_DATA;
    logic                DUTY_WE;
    logic [c_DUTY_W-1:0] DUTY_ADDR;
    logic [15:0]         DUTY_DATA;
    logic                STM_WE;
    logic                STM_SEGMENT;
    logic [c_STM_W-1:0]  STM_ADDR;
    logic [15:0]         STM_DATA;

    mem_wr_router #(
        .STM_WR_ADDR_WIDTH(c_STM_W),
        .DUTY_ADDR_WIDTH  (c_DUTY_W)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .CPU_WE     (CPU_WE),
        .CPU_ADDR   (CPU_ADDR),
        .CPU_DATA   (CPU_DATA),
        .CTL_WE     (CTL_WE),
        .CTL_ADDR   (CTL_ADDR),
        .CTL_DATA   (CTL_DATA),
        .MOD_WE     (MOD_WE),
        .MOD_SEGMENT(MOD_SEGMENT),
        .MOD_ADDR   (MOD_ADDR),
        .MOD_DATA   (MOD_DATA),
        .DUTY_WE    (DUTY_WE),
        .DUTY_ADDR  (DUTY_ADDR),
        .DUTY_DATA  (DUTY_DATA),
        .STM_WE     (STM_WE),
        .STM_SEGMENT(STM_SEGMENT),
        .STM_ADDR   (STM_ADDR),
        .STM_DATA   (STM_DATA)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: target = addr / 16384, offset = addr % 16384,
    // full BRAM address = page * 16384 + offset.
    logic [3:0]  m_we;
    int unsigned m_ctl_addr, m_ctl_data;
    int unsigned m_mod_seg_o, m_mod_addr, m_mod_data;
    int unsigned m_duty_addr, m_duty_data;
    int unsigned m_stm_seg_o, m_stm_addr, m_stm_data;
    int unsigned m_mod_seg, m_stm_seg, m_stm_page, m_duty_page;

    always @(posedge CLK) begin
        int unsigned tgt;
        int unsigned off;
        if (RST) begin
            m_we = 4'b0;
            m_ctl_addr = 0; m_ctl_data = 0;
            m_mod_seg_o = 0; m_mod_addr = 0; m_mod_data = 0;
            m_duty_addr = 0; m_duty_data = 0;
            m_stm_seg_o = 0; m_stm_addr = 0; m_stm_data = 0;
            m_mod_seg = 0; m_stm_seg = 0; m_stm_page = 0; m_duty_page = 0;
        end else begin
            m_we = 4'b0;
            if (CPU_WE) begin
                tgt = int'(CPU_ADDR) / 16384;
                off = int'(CPU_ADDR) % 16384;
                m_we[tgt] = 1'b1;
                if (tgt == 0) begin
                    m_ctl_addr = off;
                    m_ctl_data = CPU_DATA;
                    if (off == 'h20) m_mod_seg = CPU_DATA % 2;
                    if (off == 'h50) m_stm_seg = CPU_DATA % 2;
                    if (off == 'h58) m_stm_page = CPU_DATA % (1 << (c_STM_W - 14));
                    if (off == 'h60) m_duty_page = CPU_DATA % (1 << (c_DUTY_W - 14));
                end else if (tgt == 1) begin
                    m_mod_seg_o = m_mod_seg;
                    m_mod_addr = off;
                    m_mod_data = CPU_DATA;
                end else if (tgt == 2) begin
                    m_duty_addr = m_duty_page * 16384 + off;
                    m_duty_data = CPU_DATA;
                end else begin
                    m_stm_seg_o = m_stm_seg;
                    m_stm_addr = m_stm_page * 16384 + off;
                    m_stm_data = CPU_DATA;
                end
            end
        end
    end

    // Per-cycle comparison of every output against the model
    always @(negedge CLK) begin
        if (chk_en) begin
            check("we_vec",   {28'd0, STM_WE, DUTY_WE, MOD_WE, CTL_WE}, {28'd0, m_we});
            check("ctl_addr", 32'(CTL_ADDR),    m_ctl_addr);
            check("ctl_data", 32'(CTL_DATA),    m_ctl_data);
            check("mod_seg",  32'(MOD_SEGMENT), m_mod_seg_o);
            check("mod_addr", 32'(MOD_ADDR),    m_mod_addr);
            check("mod_data", 32'(MOD_DATA),    m_mod_data);
            check("duty_addr",32'(DUTY_ADDR),   m_duty_addr);
            check("duty_data",32'(DUTY_DATA),   m_duty_data);
            check("stm_seg",  32'(STM_SEGMENT), m_stm_seg_o);
            check("stm_addr", 32'(STM_ADDR),    m_stm_addr);
            check("stm_data", 32'(STM_DATA),    m_stm_data);
        end
    end

    // Present a write for one cycle; returns on the negedge after it is sampled
    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        CPU_WE = 1'b1; CPU_ADDR = a; CPU_DATA = d;
        @(negedge CLK);
    endtask

    task automatic idle();
        CPU_WE = 1'b0;
        @(negedge CLK);
    endtask

    initial begin
        RST = 1'b1; CPU_WE = 1'b0; CPU_ADDR = '0; CPU_DATA = '0;
        @(negedge CLK);
        chk_en = 1;

        // Reset held 3 cycles with CPU_WE toggling
        for (int i = 0; i < 3; i++) begin
            CPU_WE = i[0] ? 1'b0 : 1'b1; CPU_ADDR = 16'h0058; CPU_DATA = 16'h000F;
            @(negedge CLK);
            check("rst_we", {28'd0, STM_WE, DUTY_WE, MOD_WE, CTL_WE}, 32'd0);
            check("rst_stm_addr", 32'(STM_ADDR), 32'd0);
        end
        RST = 1'b0;
        idle();
        // Snoop must still be zero after reset
        wr(16'hC000, 16'h1111);
        check("rst_page", 32'(STM_ADDR), 32'h0);
        idle();

        // Routing to MOD
        wr(16'h4005, 16'hABCD);
        check("mod_we",   32'(MOD_WE),   32'd1);
        check("mod_addr_lit", 32'(MOD_ADDR), 32'h0005);
        check("mod_data_lit", 32'(MOD_DATA), 32'hABCD);
        check("mod_seg_lit",  32'(MOD_SEGMENT), 32'd0);
        check("mod_others", {29'd0, STM_WE, DUTY_WE, CTL_WE}, 32'd0);
        idle();

        // STM page, back-to-back with the BRAM write
        wr(16'h0058, 16'h000F);
        check("ctl_we_first", 32'(CTL_WE), 32'd1);
        wr(16'hC3FF, 16'h1234);
        check("stm_addr_lit", 32'(STM_ADDR), 32'h3C3FF);
        check("stm_data_lit", 32'(STM_DATA), 32'h1234);
        // Wrap-around within the page does not advance it
        wr(16'hFFFF, 16'h0001);
        check("wrap_hi", 32'(STM_ADDR), 32'h3FFFF);
        wr(16'hC000, 16'h0002);
        check("wrap_lo", 32'(STM_ADDR), 32'h3C000);
        // Upper data bits ignored by the page snoop
        wr(16'h0058, 16'hFFF3);
        wr(16'hC010, 16'h0003);
        check("page_mask", 32'(STM_ADDR), 32'h0C010);
        idle();

        // Segments
        wr(16'h0050, 16'hFFFF);
        wr(16'h0020, 16'h0001);
        wr(16'hC001, 16'h5555);
        check("stm_seg_lit", 32'(STM_SEGMENT), 32'd1);
        wr(16'h4001, 16'h6666);
        check("mod_seg_lit1", 32'(MOD_SEGMENT), 32'd1);
        // Non-CTL writes at snoop offsets must not disturb the registers
        wr(16'h4058, 16'h0000);
        wr(16'h8060, 16'h0001);
        wr(16'hC002, 16'h0004);
        check("no_snoop_bram", 32'(STM_ADDR), 32'h0C002);
        idle();

        // Duty page
        wr(16'h0060, 16'h0001);
        wr(16'h8000, 16'hBEEF);
        check("duty_addr_lit", 32'(DUTY_ADDR), 32'h4000);
        check("duty_we_lit",   32'(DUTY_WE),   32'd1);
        idle();

        // Reset coincident with a page write drops it
        RST = 1'b1; CPU_WE = 1'b1; CPU_ADDR = 16'h0058; CPU_DATA = 16'h0005;
        @(negedge CLK);
        check("rst_drop_we", 32'(CTL_WE), 32'd0);
        RST = 1'b0;
        idle();
        wr(16'hC000, 16'h7777);
        check("rst_drop_page", 32'(STM_ADDR), 32'h0);
        check("rst_drop_stmwe", 32'(STM_WE), 32'd1);
        idle();

        // Mixed traffic checked by the model, with occasional resets
        for (int i = 0; i < 300; i++) begin
            logic [13:0] off;
            case ($urandom_range(0, 4))
                0: off = 14'h020;
                1: off = 14'h050;
                2: off = 14'h058;
                3: off = 14'h060;
                default: off = 14'($urandom);
            endcase
            RST      = ($urandom_range(0, 40) == 0);
            CPU_WE   = ($urandom_range(0, 3) != 0);
            CPU_ADDR = {2'($urandom), off};
            CPU_DATA = 16'($urandom);
            @(negedge CLK);
        end
        RST = 1'b0;
        idle();
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
